rr_gate_arbiter: RTL and testbench
==================================

Name: rr_gate_arbiter

Overview:
- Round-robin arbiter sharing one gate-level datapath resource (e.g. a wide AND evaluation stage) among N requesters.
- Each requester raises req, receives a one-hot registered grant, holds the resource until it signals done, drops req, or hits a hold-time limit.
- Sits between requesting FSMs and the shared combinational gate block, and drives its input mux select.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_HOLD, 8, maximum grant length in cycles; 0 disables the timeout.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request, level-sensitive.
- done  input  N  per-requester release pulse; only the owner's bit is honoured.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_id  output  clog2(N)  binary index of owner; valid when busy=1.
- busy  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset is sampled on clk only. Next edge with rst=1 forces:
  - gnt=0, gnt_id=0, busy=0, timeout=0.
  - priority pointer ptr=0, hold counter cnt=0, state IDLE.
- rst overrides every other input in that cycle.
- States:
  - IDLE: gnt=0.
  - GRANT: exactly one gnt bit high.
- IDLE -> GRANT when req != 0:
  - Winner is the first set req bit searching circularly from ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On the next edge: gnt=onehot(winner), gnt_id=winner, busy=1, cnt=0.
  - Latency from req sampled high to gnt high: 1 cycle.
- Release conditions in GRANT, evaluated each cycle for owner o:
  - done[o]=1, or
  - req[o]=0, or
  - MAX_HOLD!=0 and cnt==MAX_HOLD-1.
- Any release condition -> IDLE on the next edge:
  - gnt=0, busy=0.
  - ptr=(o+1) mod N, so owner N-1 wraps ptr to 0.
  - cnt=0.
- timeout=1 for exactly the one cycle following the edge on which a release is caused only by the MAX_HOLD limit.
  - If done[o] or a dropped req[o] coincides with the limit, the release is normal and timeout stays 0.
- Otherwise in GRANT: cnt increments by 1 and saturates at MAX_HOLD-1. Width is clog2(MAX_HOLD+1), minimum 1.
- At least one idle cycle (gnt=0) follows every grant. This is the dead cycle for the shared datapath's input mux.
- done bits of non-owners, and done in IDLE, are ignored.
- Requests arriving during GRANT wait; there is no pre-emption.
- A requester revoked by timeout may re-win only per the round-robin order. With no other requests pending it re-wins after one idle cycle.
- gnt_id holds its last value while idle. It is don't-care for checking when busy=0, but must be deterministic.

Decomposition:
- Shared package holds:
  - State encoding: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Default parameter constants ARB_N=4, ARB_MAX_HOLD=8.
- One sub-module: rr_pick.
  - Combinational circular priority picker.
  - Inputs: req[N], ptr.
  - Outputs: winner index, any-valid flag.
- The top level holds the FSM, ptr, cnt and output registers.

Test Plan:
- Reset mid-grant: grant to requester 2 active, assert rst one cycle -> next edge gnt=0000, busy=0, timeout=0; then req=0001 gives gnt=0001 one cycle later (ptr back to 0).
- Single request: req=0100 from idle -> gnt=0100, gnt_id=2 after 1 cycle; done[2] pulse -> gnt=0000 next cycle; ptr=3.
- Fairness rotation: req=1111 held, each owner pulses done after 2 cycles -> grant order 0,1,2,3,0 with one idle cycle between each.
- Wrap: ptr=3, req=1001 -> gnt=1000; after release, req=1001 still -> gnt=0001 (wraps to 0).
- Timeout: MAX_HOLD=8, req=0010 held, no done -> gnt=0010 for exactly 8 cycles, then gnt=0000 with timeout=1 for one cycle; done coinciding with cycle 8 -> timeout stays 0.
- Ignored inputs: done=0001 while owner is 2, and done pulses while idle -> no change in gnt, ptr or cnt.

Source files
------------

// File: rtl/rr_gate_arbiter_pkg.sv
// Shared types and defaults for the round-robin gate-resource arbiter.
package rr_gate_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_N        = 4;
  localparam int unsigned ARB_MAX_HOLD = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter must represent 0..MAX_HOLD-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    return ($clog2(max_hold + 1) > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_gate_arbiter_if.sv
// Request/grant bundle between requesting FSMs (master) and the arbiter (slave).
interface rr_gate_arbiter_if
  import rr_gate_arbiter_pkg::*;
#(
  parameter int unsigned N = ARB_N
);
  localparam int unsigned IW = idx_width(N);

  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, timeout
  );

endinterface

// File: rtl/rr_gate_arbiter_rr_pick.sv
// Circular priority picker: first set request at or after ptr, wrapping past N-1.
module rr_pick
  import rr_gate_arbiter_pkg::*;
#(
  parameter int unsigned N = ARB_N
) (
  input  logic [N-1:0]              req_i,
  input  logic [idx_width(N)-1:0]   ptr_i,
  output logic [idx_width(N)-1:0]   winner_o,
  output logic                      valid_o
);
  localparam int unsigned IW = idx_width(N);

  int unsigned idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx[IW-1:0]]) begin
        valid_o  = 1'b1;
        winner_o = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_gate_arbiter.sv
// Round-robin arbiter for a shared gate datapath: one-hot registered grant,
// release on done/dropped req/hold limit, and a forced idle cycle between owners.
module rr_gate_arbiter
  import rr_gate_arbiter_pkg::*;
#(
  parameter int unsigned N        = ARB_N,
  parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  rr_gate_arbiter_if.slave bus
);
  localparam int unsigned   IW      = idx_width(N);
  localparam int unsigned   CW      = cnt_width(MAX_HOLD);
  localparam int unsigned   LIM     = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0] CNT_LIM = CW'(LIM);
  localparam logic [IW-1:0] LAST_ID = IW'(N - 1);

  arb_state_e    state_q;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_id_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q;
  logic          busy_q;
  logic          timeout_q;

  logic [IW-1:0] win;
  logic          any_req;
  logic          own_done, own_req, at_limit;
  logic          release_d, timeout_d;

  rr_pick #(.N(N)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (win),
    .valid_o  (any_req)
  );

  // Only the owner's done/req bits matter; a limit hit coinciding with a
  // normal release is reported as a normal release.
  always_comb begin
    own_done  = bus.done[gnt_id_q];
    own_req   = bus.req[gnt_id_q];
    at_limit  = (MAX_HOLD != 0) && (cnt_q == CNT_LIM);
    release_d = own_done || !own_req || at_limit;
    timeout_d = at_limit && !own_done && own_req;
    ptr_d     = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IW'(1);
    cnt_d     = (cnt_q == CNT_LIM) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q  <= ST_GRANT;
            gnt_q    <= N'(1) << win;
            gnt_id_q <= win;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        ST_GRANT: begin
          if (release_d) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
            timeout_q <= timeout_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// Scoreboard bench for rr_gate_arbiter: reference model pushes expected outputs
// per driven cycle, which are popped and compared after the clock edge.
module tb_rr_gate_arbiter;
  import rr_gate_arbiter_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned MH = 8;
  localparam int unsigned IW = idx_width(N);

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] id;
    logic          busy;
    logic          to;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_gate_arbiter_if #(.N(N)) bus ();

  rr_gate_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic          m_busy  = 1'b0;
  logic          m_to    = 1'b0;
  logic [IW-1:0] m_id    = '0;
  int unsigned   m_owner = 0;
  int unsigned   m_ptr   = 0;
  int unsigned   m_cnt   = 0;

  logic [N-1:0]  prev_gnt = '0;
  int unsigned   starts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
    logic lim;
    int unsigned j;
    if (rs) begin
      m_busy = 1'b0; m_to = 1'b0; m_id = '0;
      m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      m_to = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (r[j]) begin
          m_busy = 1'b1; m_owner = j; m_cnt = 0; m_id = IW'(j);
          break;
        end
      end
    end else begin
      lim = (m_cnt == MH - 1);
      if (d[m_owner] || !r[m_owner] || lim) begin
        m_to   = lim && !d[m_owner] && r[m_owner];
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
        m_cnt  = 0;
      end else begin
        m_to = 1'b0;
        if (m_cnt < MH - 1) m_cnt++;
      end
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
    exp_t e;
    bus.req  = r;
    bus.done = d;
    rst      = rs;
    model_step(r, d, rs);
    e.gnt  = m_busy ? (N'(1) << m_owner) : '0;
    e.id   = m_id;
    e.busy = m_busy;
    e.to   = m_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt",     32'(bus.gnt),     32'(e.gnt));
    check("gnt_id",  32'(bus.gnt_id),  32'(e.id));
    check("busy",    32'(bus.busy),    32'(e.busy));
    check("timeout", 32'(bus.timeout), 32'(e.to));
    if (prev_gnt == '0 && bus.gnt != '0) starts.push_back(32'(bus.gnt_id));
    prev_gnt = bus.gnt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int unsigned glen;
    int unsigned exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] d;

    bus.req = '0; bus.done = '0; rst = 1'b1;
    drive('0, '0, 1'b1);
    drive('0, '0, 1'b1);
    check("reset_gnt",  32'(bus.gnt),  32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);

    // Single request to 2, release by done.
    drive(4'b0100, '0, 1'b0);
    check("single_gnt", 32'(bus.gnt),    32'h4);
    check("single_id",  32'(bus.gnt_id), 32'h2);
    drive(4'b0100, '0, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    check("single_rel", 32'(bus.gnt), 32'h0);

    // ptr is now 3: wrap through 3 then 0.
    drive(4'b1001, '0, 1'b0);
    check("wrap_first", 32'(bus.gnt), 32'h8);
    drive(4'b1001, '0, 1'b0);
    drive(4'b1001, 4'b1000, 1'b0);
    drive(4'b1001, '0, 1'b0);
    check("wrap_second", 32'(bus.gnt), 32'h1);
    drive('0, '0, 1'b0);

    // Ignored done bits: non-owner while granted, all bits while idle.
    drive(4'b0100, '0, 1'b0);
    check("ign_gnt", 32'(bus.gnt), 32'h4);
    drive(4'b0100, 4'b0001, 1'b0);
    drive(4'b0100, 4'b0001, 1'b0);
    check("ign_hold", 32'(bus.gnt), 32'h4);
    drive(4'b0100, 4'b0100, 1'b0);
    drive('0, 4'b1111, 1'b0);
    drive('0, 4'b1111, 1'b0);
    drive(4'b1111, '0, 1'b0);
    check("ign_ptr", 32'(bus.gnt), 32'h8);
    drive('0, '0, 1'b0);

    // Fairness rotation from a fresh pointer; each owner holds two cycles.
    drive('0, '0, 1'b1);
    starts.delete();
    for (int unsigned c = 0; c < 40 && starts.size() < 5; c++) begin
      d = (m_busy && m_cnt == 1) ? (N'(1) << m_owner) : '0;
      drive(4'b1111, d, 1'b0);
    end
    check("rr_count", 32'(starts.size()), 32'd5);
    for (int unsigned i = 0; i < 5 && i < starts.size(); i++)
      check("rr_order", starts[i], exp_order[i]);
    drive('0, '0, 1'b0);
    drive('0, '0, 1'b0);

    // Timeout: held request with no done is revoked after MH cycles.
    drive(4'b0010, '0, 1'b0);
    glen = (bus.gnt == 4'b0010) ? 1 : 0;
    for (int unsigned c = 0; c < 20; c++) begin
      if (bus.gnt == '0) break;
      drive(4'b0010, '0, 1'b0);
      if (bus.gnt == 4'b0010) glen++;
    end
    check("to_len",   glen,               32'(MH));
    check("to_pulse", 32'(bus.timeout),   32'h1);
    drive('0, '0, 1'b0);
    check("to_clear", 32'(bus.timeout),   32'h0);

    // done coinciding with the limit cycle is a normal release.
    drive(4'b0010, '0, 1'b0);
    for (int unsigned c = 0; c < MH - 1; c++) drive(4'b0010, '0, 1'b0);
    drive(4'b0010, 4'b0010, 1'b0);
    check("to_coinc_gnt", 32'(bus.gnt),     32'h0);
    check("to_coinc_to",  32'(bus.timeout), 32'h0);
    drive('0, '0, 1'b0);

    // Reset mid-grant.
    drive('0, '0, 1'b0);
    drive(4'b0100, '0, 1'b0);
    drive(4'b0100, '0, 1'b1);
    check("rst_mid_gnt",  32'(bus.gnt),  32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    drive(4'b0001, '0, 1'b0);
    check("rst_regrant", 32'(bus.gnt), 32'h1);
    drive('0, '0, 1'b0);

    // Random traffic against the model.
    for (int unsigned c = 0; c < 300; c++) begin
      drive(N'($urandom), ($urandom_range(3) == 0) ? N'($urandom) : '0,
            ($urandom_range(49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
